gol_ctrl_fsm: RTL and testbench
===============================

Name: gol_ctrl_fsm

Overview:
Parametrised single-clock successor to the Game of Life control FSM. It sequences STOP / PROGRAM / RUN / PAUSE for a ROWS x COLS board. It drives the cell-programming write port and the per-generation evaluation sweep and commit of the update engine. It also adds a paced free-run mode, single-step while paused, and a generation counter.

Parameters:
ROWS, 8, board rows (>=1)
COLS, 16, board columns (>=1)
TICK_DIV, 4, idle cycles in RUN between generations (>=1)
GEN_W, 16, generation counter width
(localparams: N = ROWS*COLS; IDX_W = max(1, clog2(N)))

Ports:
clka  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stop  in  1  level, highest priority: force STOP
prgm  in  1  level: request/hold PROGRAM
pp  in  1  play/pause, acts on rising edge
btn0  in  1  rising edge: program dead cell (PROGRAM) / single step (PAUSE)
btn1  in  1  rising edge: program live cell (PROGRAM)
cell_idx  out  IDX_W  current cell address (write or evaluate)
cell_we  out  1  one-cycle write strobe for cell_idx
cell_wdata  out  1  value written when cell_we=1
calc_en  out  1  engine evaluates next state of cell_idx this cycle
commit  out  1  one-cycle pulse: engine swaps next->current board
game_state  out  2  00 STOP, 01 PROGRAM, 10 RUN, 11 PAUSE
gen_count  out  GEN_W  generations committed since last STOP
busy  out  1  sweep/commit (or clear) in progress

Behaviour:
- All inputs are synchronous to clka. Edge detection uses history registers that reset to 1, so inputs held high through reset never fire.
- Reset (async, any state, mid-sweep included): STOP. cell_idx=0, cell_we=0, cell_wdata=0, calc_en=0, commit=0, gen_count=0, busy=0, game_state=00. Tick counter cleared. Pending pause cleared.
- All outputs are registered.
- Internal states: STOP, PROG, RUN_WAIT, SWEEP, COMMIT, PAUSE.
- game_state mapping: 10 for RUN_WAIT, and for SWEEP/COMMIT when free-running. 11 for PAUSE, and for SWEEP/COMMIT during a single step.
- Priority in every state: stop > prgm > pp edge > button edges.
- stop=1 from any state: STOP on the next edge.
  - An in-flight sweep is aborted with no commit.
  - cell_idx=0, gen_count=0.
- STOP with stop=0:
  - prgm=1 -> PROG, cell_idx=0.
  - pp rising -> RUN_WAIT.
- PROG:
  - Edge detected at edge k -> cycle k+1 has cell_we=1 and cell_idx=target. btn1 gives cell_wdata=1; btn0 gives cell_wdata=0.
  - cell_idx increments at edge k+1, wrapping N-1 -> 0.
  - btn0 and btn1 rising in the same cycle: no write, cell_idx still increments (skip).
  - prgm=0 -> PAUSE, cell_idx=0. pp is ignored in PROG.
- PAUSE:
  - pp rising -> RUN_WAIT.
  - prgm=1 -> PROG, cell_idx=0.
  - btn0 rising -> one step: SWEEP then COMMIT, then back to PAUSE.
- RUN_WAIT:
  - Counts TICK_DIV cycles, then SWEEP.
  - pp rising -> PAUSE immediately. prgm is ignored.
- SWEEP:
  - Lasts exactly N cycles, with calc_en=1 and cell_idx = 0,1,...,N-1 in consecutive cycles.
  - Then COMMIT: one cycle with commit=1, calc_en=0, gen_count+1 (wraps at 2^GEN_W).
  - After COMMIT: RUN_WAIT with the tick counter reloaded, or PAUSE if stepping or a pause is pending. cell_idx returns to 0.
- Free-running generation period: TICK_DIV + N + 1 cycles.
- pp rising during SWEEP/COMMIT: pause latched as pending and honoured after COMMIT, so a generation is never split.
- prgm, btn0 and btn1 are ignored during SWEEP/COMMIT.
- busy=1 exactly during SWEEP and COMMIT.

Optional Feature:
GOL_CLEAR_ON_STOP_EN
- Defined:
  - Entering STOP (including after reset release) runs a clear sweep: N cycles of cell_we=1, cell_wdata=0, cell_idx 0..N-1, with busy=1 and game_state=00.
  - prgm and pp edges are ignored until the sweep completes. stop held high does not restart it.
  - Reset mid-clear restarts the clear after release.
- Undefined: STOP is idle and writes nothing. Board contents are retained.

Test Plan:
1. Defaults, reset asserted at sweep cycle 60 -> all outputs 0 immediately (async), game_state=00, gen_count=0; after release, no spurious edges with pp/btn held high.
2. prgm=1; btn1 rise, btn0 rise, btn0+btn1 rise together -> idx0 written 1, idx1 written 0, idx2 skipped, cell_idx=3; 125 further btn1 rises -> cell_idx wraps to 0.
3. From PAUSE, pp rise -> 4 cycles of game_state=10 with calc_en=0, then 128 cycles calc_en=1 (idx 0..127), commit pulse, gen_count=1; next commit 133 cycles later, gen_count=2.
4. pp rise at sweep cycle 50 -> sweep completes to idx 127, commit, gen_count increments, then game_state=11 with calc_en=0.
5. PAUSE, btn0 rise -> one 128-cycle sweep plus commit, gen_count+1, game_state stays 11 throughout; btn1 rise in PAUSE -> no activity.
6. stop=1 at sweep cycle 30 -> next cycle game_state=00, calc_en=0, no commit, gen_count=0. With GOL_CLEAR_ON_STOP_EN: 128 cycles of cell_we=1, cell_wdata=0, busy=1.

Source files
------------

// File: rtl/gol_ctrl_fsm.sv
// gol_ctrl_fsm: Game of Life control FSM (program / paced run / pause / single step, generation count).
// Define GOL_CLEAR_ON_STOP_EN to run a board-clear write sweep on every entry to STOP.
module gol_ctrl_fsm #(
   parameter int ROWS = 8,
   parameter int COLS = 16,
   parameter int TICK_DIV = 4,
   parameter int GEN_W = 16,
   localparam int N = ROWS * COLS,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clka,
   input  logic             rst_n,
   input  logic             stop,
   input  logic             prgm,
   input  logic             pp,
   input  logic             btn0,
   input  logic             btn1,
   output logic [IDX_W-1:0] cell_idx,
   output logic             cell_we,
   output logic             cell_wdata,
   output logic             calc_en,
   output logic             commit,
   output logic [1:0]       game_state,
   output logic [GEN_W-1:0] gen_count,
   output logic             busy
);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
   localparam logic [TW-1:0] RELOAD = TW'(TICK_DIV - 1);
   typedef enum logic [2:0] {S_STOP, S_PROG, S_RUN, S_SWEEP, S_COMMIT, S_PAUSE, S_CLR} state_t;
   state_t st, ns;
   logic [TW-1:0] tick, n_tick;
   logic [IDX_W-1:0] n_idx;
   logic [GEN_W-1:0] n_gen;
   logic [1:0] n_gs;
   logic step, n_step, pend, n_pend;
   logic n_we, n_wd, n_calc, n_commit, n_busy;
   logic pp_q, b0_q, b1_q, pp_r, b0_r, b1_r;
`ifdef GOL_CLEAR_ON_STOP_EN
   logic dirty, n_dirty;
`endif
   function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] i);
      return (i == LAST) ? '0 : i + 1'b1;
   endfunction
   // History registers reset high so levels held through reset never look like edges
   assign pp_r = pp & ~pp_q;
   assign b0_r = btn0 & ~b0_q;
   assign b1_r = btn1 & ~b1_q;
   always_comb begin
      ns = st;
      n_idx = cell_idx;
      n_we = 1'b0;
      n_wd = 1'b0;
      n_calc = 1'b0;
      n_commit = 1'b0;
      n_gen = gen_count;
      n_tick = tick;
      n_step = step;
      n_pend = pend;
`ifdef GOL_CLEAR_ON_STOP_EN
      n_dirty = dirty;
`endif
      if (stop && st != S_STOP && st != S_CLR) begin
         n_idx = '0;
         n_gen = '0;
         n_step = 1'b0;
         n_pend = 1'b0;
`ifdef GOL_CLEAR_ON_STOP_EN
         ns = S_CLR;
         n_we = 1'b1;
`else
         ns = S_STOP;
`endif
      end else begin
         case (st)
            S_STOP: begin
`ifdef GOL_CLEAR_ON_STOP_EN
               if (dirty) begin
                  ns = S_CLR;
                  n_we = 1'b1;
                  n_idx = '0;
                  n_dirty = 1'b0;
               end else
`endif
               if (!stop && prgm) begin
                  ns = S_PROG;
                  n_idx = '0;
               end else if (!stop && pp_r) begin
                  ns = S_RUN;
                  n_tick = RELOAD;
               end
            end
            S_CLR: begin
               if (cell_idx == LAST) begin
                  ns = S_STOP;
                  n_idx = '0;
               end else begin
                  n_idx = nxt(cell_idx);
                  n_we = 1'b1;
               end
            end
            S_PROG: begin
               if (!prgm) begin
                  ns = S_PAUSE;
                  n_idx = '0;
               end else begin
                  n_idx = cell_we ? nxt(cell_idx) : cell_idx;
                  if (b0_r ^ b1_r) begin
                     n_we = 1'b1;
                     n_wd = b1_r;
                  end else if (b0_r & b1_r) n_idx = nxt(n_idx);
               end
            end
            S_PAUSE: begin
               if (prgm) begin
                  ns = S_PROG;
                  n_idx = '0;
               end else if (pp_r) begin
                  ns = S_RUN;
                  n_tick = RELOAD;
               end else if (b0_r) begin
                  ns = S_SWEEP;
                  n_step = 1'b1;
                  n_idx = '0;
                  n_calc = 1'b1;
               end
            end
            S_RUN: begin
               if (pp_r) ns = S_PAUSE;
               else if (tick == '0) begin
                  ns = S_SWEEP;
                  n_step = 1'b0;
                  n_idx = '0;
                  n_calc = 1'b1;
               end else n_tick = tick - 1'b1;
            end
            S_SWEEP: begin
               n_pend = pend | pp_r;
               if (cell_idx == LAST) begin
                  ns = S_COMMIT;
                  n_commit = 1'b1;
                  n_idx = '0;
                  n_gen = gen_count + 1'b1;
               end else begin
                  n_idx = nxt(cell_idx);
                  n_calc = 1'b1;
               end
            end
            S_COMMIT: begin
               ns = (step | pend | pp_r) ? S_PAUSE : S_RUN;
               n_tick = RELOAD;
               n_step = 1'b0;
               n_pend = 1'b0;
            end
            default: ns = S_STOP;
         endcase
      end
      n_gs = (ns == S_PROG) ? 2'b01 : (ns == S_RUN) ? 2'b10 : (ns == S_PAUSE) ? 2'b11 :
             (ns == S_SWEEP || ns == S_COMMIT) ? {1'b1, n_step} : 2'b00;
      n_busy = ns == S_SWEEP || ns == S_COMMIT || ns == S_CLR;
   end
   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         st <= S_STOP;
         cell_idx <= '0;
         cell_we <= 1'b0;
         cell_wdata <= 1'b0;
         calc_en <= 1'b0;
         commit <= 1'b0;
         game_state <= 2'b00;
         gen_count <= '0;
         busy <= 1'b0;
         tick <= '0;
         step <= 1'b0;
         pend <= 1'b0;
         pp_q <= 1'b1;
         b0_q <= 1'b1;
         b1_q <= 1'b1;
`ifdef GOL_CLEAR_ON_STOP_EN
         dirty <= 1'b1;
`endif
      end else begin
         st <= ns;
         cell_idx <= n_idx;
         cell_we <= n_we;
         cell_wdata <= n_wd;
         calc_en <= n_calc;
         commit <= n_commit;
         game_state <= n_gs;
         gen_count <= n_gen;
         busy <= n_busy;
         tick <= n_tick;
         step <= n_step;
         pend <= n_pend;
         pp_q <= pp;
         b0_q <= btn0;
         b1_q <= btn1;
`ifdef GOL_CLEAR_ON_STOP_EN
         dirty <= n_dirty;
`endif
      end
   end
endmodule

// File: tb/tb_gol_ctrl_fsm.sv
// tb_gol_ctrl_fsm: scoreboard bench for gol_ctrl_fsm (8x16 board, TICK_DIV 4).
module tb_gol_ctrl_fsm;
   localparam int N = 128;
   localparam int IDX_W = 7;
   localparam int GEN_W = 16;
`ifdef GOL_CLEAR_ON_STOP_EN
   localparam int CLR_N = N;
`else
   localparam int CLR_N = 0;
`endif
   logic clka = 1'b0, rst_n = 1'b0, stop = 1'b0, prgm = 1'b0;
   logic pp = 1'b1, btn0 = 1'b1, btn1 = 1'b1;
   logic [IDX_W-1:0] cell_idx;
   logic cell_we, cell_wdata, calc_en, commit, busy;
   logic [1:0] game_state;
   logic [GEN_W-1:0] gen_count;
   logic [1:0] exp_sweep_gs = 2'b10;
   int n_chk = 0, n_pass = 0, cyc = 0, sweep_cnt = 0, clr_cnt = 0, mon_e;
   int wq[$];
   int cq[$];
   gol_ctrl_fsm #(.ROWS(8), .COLS(16), .TICK_DIV(4), .GEN_W(GEN_W)) dut (
      .clka(clka), .rst_n(rst_n), .stop(stop), .prgm(prgm), .pp(pp), .btn0(btn0), .btn1(btn1),
      .cell_idx(cell_idx), .cell_we(cell_we), .cell_wdata(cell_wdata), .calc_en(calc_en),
      .commit(commit), .game_state(game_state), .gen_count(gen_count), .busy(busy)
   );
   always #5 clka = ~clka;
   always @(posedge clka) cyc++;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask
   // Writes and commits are matched against expectations queued when the stimulus was driven
   always @(negedge clka) if (rst_n) begin
      if (cell_we && game_state == 2'b00) begin
         check("clr_wdata", cell_wdata, 0);
         clr_cnt++;
      end else if (cell_we) begin
         if (wq.size() == 0) check("we_unexpected", wq.size(), 1);
         else begin
            mon_e = wq.pop_front();
            check("we_idx", cell_idx, mon_e >> 1);
            check("we_data", cell_wdata, mon_e & 1);
         end
      end
      if (calc_en) begin
         check("sweep_idx", cell_idx, sweep_cnt);
         check("sweep_gs", game_state, exp_sweep_gs);
         check("sweep_busy", busy, 1);
         sweep_cnt++;
      end else if (commit) begin
         check("sweep_len", sweep_cnt, N);
         check("commit_gs", game_state, exp_sweep_gs);
         if (cq.size() == 0) check("commit_unexpected", cq.size(), 1);
         else check("commit_gen", gen_count, cq.pop_front());
         sweep_cnt = 0;
      end else sweep_cnt = 0;
   end
   task automatic step_cycles(input int n);
      repeat (n) @(posedge clka);
      #1;
   endtask
   task automatic pulse_btn(input logic b0, input logic b1);
      btn0 = b0;
      btn1 = b1;
      @(posedge clka);
      #1;
      btn0 = 1'b0;
      btn1 = 1'b0;
      step_cycles(2);
   endtask
   task automatic pulse_pp;
      pp = 1'b1;
      @(posedge clka);
      #1;
      pp = 1'b0;
   endtask
   task automatic wait_commit(output int at);
      int found = 0;
      at = 0;
      for (int i = 0; i < 400 && found == 0; i++) begin
         @(negedge clka);
         if (commit) begin
            found = 1;
            at = cyc;
         end
      end
      check("commit_seen", found, 1);
   endtask
   task automatic wait_idx(input int k);
      int found = 0;
      for (int i = 0; i < 400 && found == 0; i++) begin
         @(negedge clka);
         if (calc_en && cell_idx == k[IDX_W-1:0]) found = 1;
      end
      check("sweep_idx_seen", found, 1);
   endtask
   task automatic wait_idle;
      int found = 0;
      for (int i = 0; i < 400 && found == 0; i++) begin
         @(negedge clka);
         if (!busy) found = 1;
      end
      check("idle_seen", found, 1);
   endtask
   task automatic check_reset_outputs;
      check("rst_idx", cell_idx, 0);
      check("rst_we", cell_we, 0);
      check("rst_wdata", cell_wdata, 0);
      check("rst_calc", calc_en, 0);
      check("rst_commit", commit, 0);
      check("rst_gs", game_state, 0);
      check("rst_gen", gen_count, 0);
      check("rst_busy", busy, 0);
   endtask
   initial begin
      int t0, t1;
      #23;
      check_reset_outputs();
      @(posedge clka);
      #1 rst_n = 1'b1;
      wait_idle();
      check("init_clr_cnt", clr_cnt, CLR_N);
      repeat (3) begin
         @(negedge clka);
         check("init_gs", game_state, 0);
         check("init_we", cell_we, 0);
      end
      @(posedge clka);
      #1;
      pp = 1'b0;
      btn0 = 1'b0;
      btn1 = 1'b0;
      step_cycles(2);
      prgm = 1'b1;
      step_cycles(2);
      check("prog_gs", game_state, 1);
      check("prog_idx0", cell_idx, 0);
      wq.push_back(0 * 2 + 1);
      pulse_btn(1'b0, 1'b1);
      wq.push_back(1 * 2 + 0);
      pulse_btn(1'b1, 1'b0);
      pulse_btn(1'b1, 1'b1);
      check("prog_skip_idx", cell_idx, 3);
      for (int i = 3; i < N; i++) begin
         wq.push_back(i * 2 + 1);
         pulse_btn(1'b0, 1'b1);
      end
      check("prog_wrap_idx", cell_idx, 0);
      check("prog_wq_left", wq.size(), 0);
      prgm = 1'b0;
      step_cycles(2);
      check("pause_gs", game_state, 3);
      check("pause_idx", cell_idx, 0);
      exp_sweep_gs = 2'b10;
      cq.push_back(1);
      pulse_pp();
      repeat (4) begin
         @(negedge clka);
         check("wait_gs", game_state, 2);
         check("wait_calc", calc_en, 0);
      end
      wait_commit(t0);
      cq.push_back(2);
      wait_commit(t1);
      check("gen_period", t1 - t0, 4 + N + 1);
      check("gen_two", gen_count, 2);
      cq.push_back(3);
      wait_idx(50);
      pulse_pp();
      wait_commit(t0);
      repeat (10) begin
         @(negedge clka);
         check("pend_pause_gs", game_state, 3);
         check("pend_pause_calc", calc_en, 0);
         check("pend_pause_busy", busy, 0);
      end
      exp_sweep_gs = 2'b11;
      cq.push_back(4);
      pulse_btn(1'b1, 1'b0);
      wait_commit(t0);
      repeat (5) begin
         @(negedge clka);
         check("step_done_gs", game_state, 3);
         check("step_done_calc", calc_en, 0);
      end
      check("step_gen", gen_count, 4);
      pulse_btn(1'b0, 1'b1);
      repeat (10) begin
         @(negedge clka);
         check("pause_btn1_calc", calc_en, 0);
         check("pause_btn1_we", cell_we, 0);
      end
      exp_sweep_gs = 2'b10;
      clr_cnt = 0;
      pulse_pp();
      wait_idx(30);
      stop = 1'b1;
      @(negedge clka);
      check("stop_gs", game_state, 0);
      check("stop_calc", calc_en, 0);
      check("stop_commit", commit, 0);
      check("stop_gen", gen_count, 0);
      check("stop_idx", cell_idx, 0);
      check("stop_we", cell_we, CLR_N > 0);
      check("stop_busy", busy, CLR_N > 0);
      wait_idle();
      check("stop_clr_cnt", clr_cnt, CLR_N);
      repeat (5) begin
         @(negedge clka);
         check("stop_hold_gs", game_state, 0);
         check("stop_hold_we", cell_we, 0);
      end
      #1 stop = 1'b0;
      step_cycles(2);
      pulse_pp();
      wait_idx(60);
      #2;
      rst_n = 1'b0;
      pp = 1'b1;
      btn0 = 1'b1;
      btn1 = 1'b1;
      clr_cnt = 0;
      #1;
      check_reset_outputs();
      @(posedge clka);
      #1 rst_n = 1'b1;
      wait_idle();
      check("rerst_clr_cnt", clr_cnt, CLR_N);
      repeat (5) begin
         @(negedge clka);
         check("rerst_gs", game_state, 0);
         check("rerst_calc", calc_en, 0);
         check("rerst_we", cell_we, 0);
      end
      check("wq_left", wq.size(), 0);
      check("cq_left", cq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish before 2ms");
      $fatal(1, "timeout");
   end
endmodule
